bpu_nextpc: RTL and testbench

- Parametrised next-PC generator: successor to the fixed `+FETCH_WIDTH` fetch-address stepper.
- Holds the fetch PC, presents it to the IFU over a valid/ready handshake, and predicts the following PC.
- Prediction uses a direct-mapped BTB with 2-bit saturating counters.
- Accepts backend redirects and branch-resolution updates; sits between backend and IFU at the head of the front end.

---
 rtl/bpu_pkg.sv | 31 +++
 rtl/bpu_btb.sv | 127 ++++++++++++
 rtl/bpu_nextpc.sv | 181 ++++++++++++++++++
 tb/tb_bpu_nextpc.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the next-PC generator and its BTB.
package bpu_pkg;

  // 2-bit saturating branch-direction counter
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // Fetch sequencer state: RST holds fetch_valid low for one cycle after reset
  typedef enum logic {
    RST = 1'b0,
    RUN = 1'b1
  } state_e;

  function automatic ctr_e ctr_inc(input ctr_e c);
    return (c == ST) ? ST : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

  // Upper counter bit is the predicted direction
  function automatic logic ctr_taken(input ctr_e c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer.
// Valid bits and counters are async-reset flops; tags and targets live in a
// reset-free array so they map onto distributed RAM. One combinational read
// port for prediction, one synchronous write port for branch resolution.
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned FETCH_BYTES = 16,
  parameter int unsigned BTB_ENTRIES = 64,
  localparam int unsigned OFF_W      = $clog2(FETCH_BYTES),
  localparam int unsigned BLK_W      = PC_WIDTH - OFF_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // prediction lookup (block address = pc without byte offset)
  input  logic [BLK_W-1:0]    rd_blk_i,
  output logic                rd_hit_o,
  output logic                rd_taken_o,
  output logic [PC_WIDTH-1:0] rd_target_o,
  // branch-resolution update
  input  logic                upd_valid_i,
  input  logic [BLK_W-1:0]    upd_blk_i,
  input  logic                upd_taken_i,
  input  logic [PC_WIDTH-1:0] upd_target_i,
  output logic                upd_pred_taken_o
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = BLK_W - IDX_W;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [PC_WIDTH-1:0] target;
    ctr_e                ctr;
  } btb_entry_t;

  logic [BTB_ENTRIES-1:0]      valid_vec;
  logic [BTB_ENTRIES-1:0][1:0] ctr_vec;
  logic [TAG_W-1:0]            tag_mem    [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]         target_mem [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  btb_entry_t       rd_entry;
  logic             upd_hit;
  ctr_e             upd_ctr;
  logic             mem_we;

  assign rd_idx  = rd_blk_i[IDX_W-1:0];
  assign rd_tag  = rd_blk_i[BLK_W-1:IDX_W];
  assign upd_idx = upd_blk_i[IDX_W-1:0];
  assign upd_tag = upd_blk_i[BLK_W-1:IDX_W];

  // Prediction read port: gather the indexed entry and test for a tag hit
  always_comb begin
    rd_entry = '{
      valid:  valid_vec[rd_idx],
      tag:    tag_mem[rd_idx],
      target: target_mem[rd_idx],
      ctr:    ctr_e'(ctr_vec[rd_idx])
    };
  end

  assign rd_hit_o    = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign rd_taken_o  = rd_hit_o && ctr_taken(rd_entry.ctr);
  assign rd_target_o = rd_entry.target;

  // Update-side lookup sees the contents before this cycle's write
  assign upd_hit          = valid_vec[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign upd_ctr          = ctr_e'(ctr_vec[upd_idx]);
  assign upd_pred_taken_o = upd_hit && ctr_taken(upd_ctr);

  // A taken resolution always (re)writes tag and target: on a hit the tag is
  // unchanged, on a miss this is the allocation
  assign mem_we = upd_valid_i && upd_taken_i;

  // Tag/target storage write port
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= upd_target_i;
    end
  end

  generate
    for (genvar gi = 0; gi < int'(BTB_ENTRIES); gi++) begin : g_entry
      logic valid_q, valid_d;
      ctr_e ctr_q, ctr_d;
      logic sel;

      assign sel = upd_valid_i && (upd_idx == IDX_W'(gi));

      // Hits train the counter; a taken miss allocates as weakly taken
      always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        if (sel) begin
          if (upd_hit) begin
            ctr_d = upd_taken_i ? ctr_inc(ctr_q) : ctr_dec(ctr_q);
          end else if (upd_taken_i) begin
            valid_d = 1'b1;
            ctr_d   = WT;
          end
        end
      end

      // Entry state flops, cleared to invalid / weak not-taken
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          valid_q <= 1'b0;
          ctr_q   <= WNT;
        end else begin
          valid_q <= valid_d;
          ctr_q   <= ctr_d;
        end
      end

      assign valid_vec[gi] = valid_q;
      assign ctr_vec[gi]   = ctr_q;
    end
  endgenerate

endmodule

// File: rtl/bpu_nextpc.sv
// Next-PC generator: holds the fetch PC, hands it to the IFU over
// valid/ready and predicts the following block from a direct-mapped BTB.
// Optional build macro BPU_PERF_CNT_EN adds lookup/hit/mispredict counters.
module bpu_nextpc
  import bpu_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         FETCH_BYTES = 16,
  parameter int unsigned         BTB_ENTRIES = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(32'h8000_0000)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                fetch_valid_o,
  input  logic                fetch_ready_i,
  output logic [PC_WIDTH-1:0] fetch_pc_o,
  output logic                pred_taken_o,
  output logic [PC_WIDTH-1:0] pred_target_o,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  input  logic                upd_valid_i,
  input  logic [PC_WIDTH-1:0] upd_pc_i,
  input  logic                upd_taken_i,
  input  logic [PC_WIDTH-1:0] upd_target_i
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]         perf_lookups_o,
  output logic [31:0]         perf_hits_o,
  output logic [31:0]         perf_upd_miss_o
`endif
);

  localparam int unsigned OFF_W = $clog2(FETCH_BYTES);
  localparam int unsigned BLK_W = PC_WIDTH - OFF_W;

  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] pc;
    logic                taken;
    logic [PC_WIDTH-1:0] target;
  } bpu_upd_t;

  state_e              state_q, state_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  bpu_upd_t            upd;
  logic                rd_hit;
  logic                rd_taken;
  logic [PC_WIDTH-1:0] rd_target;
  logic                upd_pred_taken;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] pred_target;
  logic                handshake;
  logic                unused_upd_off;

  assign upd = '{
    valid:  upd_valid_i,
    pc:     upd_pc_i,
    taken:  upd_taken_i,
    target: upd_target_i
  };

  // The BTB works on block addresses; byte offset within the block is ignored
  assign unused_upd_off = ^upd.pc[OFF_W-1:0];

  bpu_btb #(
    .PC_WIDTH    (PC_WIDTH),
    .FETCH_BYTES (FETCH_BYTES),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .rd_blk_i         (pc_q[PC_WIDTH-1:OFF_W]),
    .rd_hit_o         (rd_hit),
    .rd_taken_o       (rd_taken),
    .rd_target_o      (rd_target),
    .upd_valid_i      (upd.valid),
    .upd_blk_i        (upd.pc[PC_WIDTH-1:OFF_W]),
    .upd_taken_i      (upd.taken),
    .upd_target_i     (upd.target),
    .upd_pred_taken_o (upd_pred_taken)
  );

  // Fall-through is the next aligned block; the add wraps at the top of memory
  assign seq_pc      = {pc_q[PC_WIDTH-1:OFF_W] + BLK_W'(1), {OFF_W{1'b0}}};
  assign pred_target = rd_taken ? rd_target : seq_pc;
  assign handshake   = fetch_valid_q && fetch_ready_i;

  // Sequencer: leave RST on the first edge after reset release
  always_comb begin
    state_d       = state_q;
    fetch_valid_d = fetch_valid_q;
    case (state_q)
      RST: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      default: begin
        state_d       = RST;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  // Next PC: redirect beats an accepted fetch; otherwise hold
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (handshake) begin
      pc_d = pred_target;
    end
  end

  // Sequencer state, registered fetch_valid and the fetch PC
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= RST;
      fetch_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      pc_q          <= pc_d;
    end
  end

  assign fetch_valid_o = fetch_valid_q;
  assign fetch_pc_o    = pc_q;
  assign pred_taken_o  = rd_taken;
  assign pred_target_o = pred_target;

`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_lookups_q, perf_lookups_d;
  logic [31:0] perf_hits_q, perf_hits_d;
  logic [31:0] perf_upd_miss_q, perf_upd_miss_d;

  // Count every IFU acceptance, the hits among them, and updates that
  // disagree with what the BTB would have predicted (miss = not taken)
  always_comb begin
    perf_lookups_d  = perf_lookups_q;
    perf_hits_d     = perf_hits_q;
    perf_upd_miss_d = perf_upd_miss_q;
    if (handshake) begin
      perf_lookups_d = perf_lookups_q + 32'd1;
      if (rd_hit) begin
        perf_hits_d = perf_hits_q + 32'd1;
      end
    end
    if (upd.valid && (upd.taken != upd_pred_taken)) begin
      perf_upd_miss_d = perf_upd_miss_q + 32'd1;
    end
  end

  // Performance counter registers, wrapping at 2^32
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_lookups_q  <= 32'd0;
      perf_hits_q     <= 32'd0;
      perf_upd_miss_q <= 32'd0;
    end else begin
      perf_lookups_q  <= perf_lookups_d;
      perf_hits_q     <= perf_hits_d;
      perf_upd_miss_q <= perf_upd_miss_d;
    end
  end

  assign perf_lookups_o  = perf_lookups_q;
  assign perf_hits_o     = perf_hits_q;
  assign perf_upd_miss_o = perf_upd_miss_q;
`else
  logic unused_perf_src;
  assign unused_perf_src = rd_hit ^ upd_pred_taken;
`endif

endmodule

// File: tb/tb_bpu_nextpc.sv
// Testbench for bpu_nextpc: directed walk through the fetch/predict/redirect
// scenarios followed by randomized traffic, checked by a scoreboard fed from
// a behavioural model of the fetch PC and BTB.
`timescale 1ns/1ps
module tb_bpu_nextpc;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_lookups;
  logic [31:0] perf_hits;
  logic [31:0] perf_upd_miss;
`endif

  bpu_nextpc #(
    .PC_WIDTH    (32),
    .FETCH_BYTES (16),
    .BTB_ENTRIES (64),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .fetch_valid_o    (fetch_valid),
    .fetch_ready_i    (fetch_ready),
    .fetch_pc_o       (fetch_pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_taken_i      (upd_taken),
    .upd_target_i     (upd_target)
`ifdef BPU_PERF_CNT_EN
    ,
    .perf_lookups_o   (perf_lookups),
    .perf_hits_o      (perf_hits),
    .perf_upd_miss_o  (perf_upd_miss)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];

  logic        m_run;
  logic [31:0] m_pc;
  logic [31:0] m_blk [int];   // block address (pc/16) owning each BTB slot
  logic [31:0] m_tgt [int];
  int          m_ctr [int];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 4) % 32'd64);
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    if (!m_blk.exists(i)) return 1'b0;
    return m_blk[i] == (pc >> 4);
  endfunction

  task automatic m_reset();
    m_run = 1'b0;
    m_pc  = RST_PC;
    m_blk.delete();
    m_tgt.delete();
    m_ctr.delete();
  endtask

  // Drive one cycle of inputs, record what the DUT must show this cycle,
  // then advance the model across the coming clock edge.
  task automatic issue(input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt);
    exp_t        e;
    logic        tk;
    logic [31:0] tg;
    int          i;
    fetch_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    upd_valid      = uv;
    upd_pc         = upd_pc_sel(upc);
    upd_taken      = ut;
    upd_target     = utgt;
    tk = 1'b0;
    if (m_hit(m_pc)) tk = (m_ctr[idx_of(m_pc)] >= 2);
    tg = tk ? m_tgt[idx_of(m_pc)] : ((m_pc & ~32'hF) + 32'd16);
    e = '{valid: m_run, pc: m_pc, taken: tk, target: tg};
    exp_q.push_back(e);
    if (rv) m_pc = rpc;
    else if (m_run && rdy) m_pc = tg;
    if (uv) begin
      i = idx_of(upc);
      if (m_hit(upc)) begin
        if (ut) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ut) begin
        m_blk[i] = upc >> 4;
        m_tgt[i] = utgt;
        m_ctr[i] = 2;
      end
    end
    m_run = 1'b1;
  endtask

  function automatic logic [31:0] upd_pc_sel(input logic [31:0] p);
    return p;
  endfunction

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt);
    @(posedge clk);
    #1;
    issue(rdy, rv, rpc, uv, upc, ut, utgt);
  endtask

  task automatic go(input logic rdy);
    step(rdy, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic redir(input logic rdy, input logic [31:0] rpc);
    step(rdy, 1'b1, rpc, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic train(input logic rdy, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt);
    step(rdy, 1'b0, 32'h0, 1'b1, upc, ut, utgt);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    issue(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h8000_0400;
    return base + ($urandom_range(0, 31) << 4) + $urandom_range(0, 15);
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.valid});
        chk("fetch_pc", fetch_pc, e.pc);
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, e.taken});
        chk("pred_target", pred_target, e.target);
        $display("cyc valid=%0b pc=%h taken=%0b target=%h", fetch_valid, fetch_pc, pred_taken, pred_target);
      end else if (!rst && fetch_valid) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid=1 pc=%h expected no output at %0t", fetch_pc, $time);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    rst = 1'b1;
    fetch_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    upd_valid = 1'b0;
    upd_pc = 32'h0;
    upd_taken = 1'b0;
    upd_target = 32'h0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_pc", fetch_pc, RST_PC);
    chk("rst_target", pred_target, 32'h8000_0010);

    release_reset();                                // RST cycle
    chk("rst_cycle_valid", {31'b0, fetch_valid}, 32'h0);
    go(1'b1);  chk("first_pc", fetch_pc, 32'h8000_0000);
    go(1'b1);  chk("seq_pc1", fetch_pc, 32'h8000_0010);
    go(1'b0);  chk("seq_pc2", fetch_pc, 32'h8000_0020);
    go(1'b0);  chk("stall1", fetch_pc, 32'h8000_0020);
    go(1'b0);  chk("stall2", fetch_pc, 32'h8000_0020);
    train(1'b1, 32'h8000_0040, 1'b1, 32'h8000_1000);
    chk("stall_release", fetch_pc, 32'h8000_0020);
    go(1'b1);  chk("after_stall", fetch_pc, 32'h8000_0030);
    train(1'b1, 32'h8000_0040, 1'b0, 32'h0);        // 2 -> 1
    chk("hit_taken", {31'b0, pred_taken}, 32'h1);
    chk("hit_target", pred_target, 32'h8000_1000);
    train(1'b1, 32'h8000_0040, 1'b0, 32'h0);        // 1 -> 0
    chk("jump_pc", fetch_pc, 32'h8000_1000);
    redir(1'b1, 32'h8000_0040);
    go(1'b1);
    chk("nt_fallthru_taken", {31'b0, pred_taken}, 32'h0);
    chk("nt_fallthru_target", pred_target, 32'h8000_0050);
    redir(1'b1, 32'h9000_0000);                     // handshake discarded
    chk("fallthru_pc", fetch_pc, 32'h8000_0050);
    go(1'b1);  chk("redir_hs", fetch_pc, 32'h9000_0000);
    redir(1'b0, 32'h9000_0000);
    chk("pre_redir_nr", fetch_pc, 32'h9000_0010);
    redir(1'b1, 32'hA000_0000);                     // back-to-back redirects
    chk("redir_nr", fetch_pc, 32'h9000_0000);
    redir(1'b1, 32'hFFFF_FFF0);
    chk("b2b_first", fetch_pc, 32'hA000_0000);
    go(1'b1);  chk("top_pc", fetch_pc, 32'hFFFF_FFF0);
    redir(1'b1, 32'h8000_0000);
    chk("wrap_pc", fetch_pc, 32'h0000_0000);

    // randomized traffic in a small aliasing address window
    for (int n = 0; n < 1500; n++) begin
      logic        rdy;
      logic        rv;
      logic        uv;
      logic        ut;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      uv  = ($urandom_range(0, 2) == 0);
      ut  = ($urandom_range(0, 3) != 0);
      step(rdy, rv, rand_pc(), uv, rand_pc(), ut, rand_pc());
    end

    // make sure 0x8000_0040 is trained taken, then reset between edges
    train(1'b0, 32'h8000_0040, 1'b1, 32'h8000_2000);
    train(1'b0, 32'h8000_0040, 1'b1, 32'h8000_2000);
    redir(1'b0, 32'h8000_0040);
    go(1'b0);
    chk("pre_reset_hit", {31'b0, pred_taken}, 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", {31'b0, fetch_valid}, 32'h0);
    chk("async_pc", fetch_pc, RST_PC);
    chk("async_taken", {31'b0, pred_taken}, 32'h0);
`ifdef BPU_PERF_CNT_EN
    chk("perf_lookups_rst", perf_lookups, 32'h0);
    chk("perf_hits_rst", perf_hits, 32'h0);
    chk("perf_upd_miss_rst", perf_upd_miss, 32'h0);
`endif
    m_reset();
    @(negedge clk);
    release_reset();
    redir(1'b1, 32'h8000_0040);
    go(1'b0);
    chk("post_reset_miss", {31'b0, pred_taken}, 32'h0);
    chk("post_reset_target", pred_target, 32'h8000_0050);
    go(1'b1);
    go(1'b1);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
